// File: rtl/key_entry_if.sv
// key_entry_if: keypad sense/code inputs and key event/buffer outputs.
// master drives the raw keypad side, slave is the key_entry block.
interface key_entry_if;
  logic [3:0]  SWC;
  logic [3:0]  key;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry;
  logic [2:0]  digit_cnt;
  logic        entry_done;
  logic [15:0] entry_value;

  modport master (
    output SWC, key,
    input  key_valid, key_code, entry,
    input  digit_cnt, entry_done, entry_value
  );

  modport slave (
    input  SWC, key,
    output key_valid, key_code, entry,
    output digit_cnt, entry_done, entry_value
  );
endinterface

// File: rtl/key_entry.sv
// key_entry: window-debounced keypad FSM feeding a 4-digit BCD buffer.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
module key_entry #(
  parameter int DEB_WIN    = 8,
  parameter int REPEAT_DLY = 40,
  parameter int REPEAT_PER = 10
) (
  input logic        clk,
  input logic        rst_n,
  key_entry_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, PRESS_DB, HELD, REL_DB
  } state_t;

  localparam logic [3:0] DEB = 4'(DEB_WIN);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_win;
  logic        r_hit;
  logic [3:0]  r_deb, w_deb_nxt;
  logic        w_hit_now, w_win_end, w_raw;
  logic        w_confirm, w_repeat;
  logic        r_key_valid;
  logic [3:0]  r_key_code;
  logic [15:0] r_entry, r_entry_value;
  logic [2:0]  r_cnt;
  logic        r_entry_done;

  assign w_hit_now = (bus.SWC != 4'b1111);
  assign w_win_end = (r_win == 2'd3);
  assign w_raw     = r_hit | w_hit_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= 2'd0;
      r_hit <= 1'b0;
    end else begin
      r_win <= r_win + 2'd1;
      if (w_win_end)
        r_hit <= 1'b0;
      else if (w_hit_now)
        r_hit <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_deb   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_deb   <= w_deb_nxt;
    end
  end

  // DEB_WIN of 1 confirms on the first window, so skip the DB states.
  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb;
    w_confirm   = 1'b0;
    if (w_win_end) begin
      unique case (r_state)
        IDLE: begin
          if (w_raw) begin
            if (DEB == 4'd1) begin
              w_state_nxt = HELD;
              w_confirm   = 1'b1;
              w_deb_nxt   = 4'd0;
            end else begin
              w_state_nxt = PRESS_DB;
              w_deb_nxt   = 4'd1;
            end
          end
        end
        PRESS_DB: begin
          if (!w_raw) begin
            w_state_nxt = IDLE;
            w_deb_nxt   = 4'd0;
          end else if (r_deb + 4'd1 == DEB) begin
            w_state_nxt = HELD;
            w_confirm   = 1'b1;
            w_deb_nxt   = 4'd0;
          end else begin
            w_deb_nxt = r_deb + 4'd1;
          end
        end
        HELD: begin
          if (!w_raw) begin
            if (DEB == 4'd1) begin
              w_state_nxt = IDLE;
              w_deb_nxt   = 4'd0;
            end else begin
              w_state_nxt = REL_DB;
              w_deb_nxt   = 4'd1;
            end
          end
        end
        REL_DB: begin
          if (w_raw) begin
            w_state_nxt = HELD;
            w_deb_nxt   = 4'd0;
          end else if (r_deb + 4'd1 == DEB) begin
            w_state_nxt = IDLE;
            w_deb_nxt   = 4'd0;
          end else begin
            w_deb_nxt = r_deb + 4'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_deb_nxt   = 4'd0;
        end
      endcase
    end
  end

`ifdef KEY_REPEAT_EN
  localparam logic [15:0] RDLY = 16'(REPEAT_DLY);
  localparam logic [15:0] RPER = 16'(REPEAT_PER);

  logic [15:0] r_rep, w_rep_nxt;
  logic        r_rep_on, w_rep_on_nxt;

  // Counts held windows; first period is RDLY, later ones RPER.
  always_comb begin
    w_rep_nxt    = r_rep;
    w_rep_on_nxt = r_rep_on;
    w_repeat     = 1'b0;
    if (r_state != HELD || w_state_nxt != HELD) begin
      w_rep_nxt    = 16'd0;
      w_rep_on_nxt = 1'b0;
    end else if (w_win_end) begin
      if (r_rep + 16'd1 == (r_rep_on ? RPER : RDLY)) begin
        w_repeat     = 1'b1;
        w_rep_nxt    = 16'd0;
        w_rep_on_nxt = 1'b1;
      end else begin
        w_rep_nxt = r_rep + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep    <= 16'd0;
      r_rep_on <= 1'b0;
    end else begin
      r_rep    <= w_rep_nxt;
      r_rep_on <= w_rep_on_nxt;
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_valid <= 1'b0;
      r_key_code  <= 4'd0;
    end else begin
      r_key_valid <= w_confirm | w_repeat;
      if (w_confirm)
        r_key_code <= bus.key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry       <= 16'd0;
      r_cnt         <= 3'd0;
      r_entry_value <= 16'd0;
      r_entry_done  <= 1'b0;
    end else begin
      r_entry_done <= 1'b0;
      if (r_key_valid) begin
        unique case (1'b1)
          (r_key_code <= 4'd9): begin
            r_entry <= {r_entry[11:0], r_key_code};
            if (r_cnt != 3'd4)
              r_cnt <= r_cnt + 3'd1;
          end
          (r_key_code == 4'hA): begin
            r_entry <= 16'd0;
            r_cnt   <= 3'd0;
          end
          (r_key_code == 4'hB): begin
            r_entry_value <= r_entry;
            r_entry_done  <= 1'b1;
            r_entry       <= 16'd0;
            r_cnt         <= 3'd0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.key_valid   = r_key_valid;
  assign bus.key_code    = r_key_code;
  assign bus.entry       = r_entry;
  assign bus.digit_cnt   = r_cnt;
  assign bus.entry_done  = r_entry_done;
  assign bus.entry_value = r_entry_value;
endmodule

// File: tb/tb_key_entry.sv
// tb_key_entry: directed keypad presses, scoreboard of expected key events.
// Build with +define+KEY_REPEAT_EN to exercise the auto-repeat case.
module tb_key_entry;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] tb_win;
  int n_chk = 0;
  int n_fail = 0;

  key_entry_if bus ();

  key_entry #(
    .DEB_WIN(8),
    .REPEAT_DLY(40),
    .REPEAT_PER(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_win <= 2'd0;
    else        tb_win <= tb_win + 2'd1;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] ent;
    logic [2:0]  cnt;
    logic        done;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: each key_valid pops one event, buffer checked a cycle later.
  initial begin : monitor
    exp_t e;
    logic pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("entry", bus.entry, e.ent);
        chk("digit_cnt", 16'(bus.digit_cnt), 16'(e.cnt));
        chk("entry_done", 16'(bus.entry_done), 16'(e.done));
        chk("entry_value", bus.entry_value, e.val);
        pend = 1'b0;
      end else if (bus.entry_done) begin
        chk("spurious entry_done", 16'd1, 16'd0);
      end
      if (bus.key_valid) begin
        if (q.size() == 0) begin
          chk("unexpected key_valid", 16'(bus.key_code), 16'hFFFF);
        end else begin
          e = q.pop_front();
          chk("key_code", 16'(bus.key_code), 16'(e.code));
          pend = 1'b1;
        end
      end
    end
  end

  task automatic align();
    @(negedge clk);
    while (tb_win != 2'd0) @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] k, input int nw, input logic dn);
    bus.key = k;
    bus.SWC = dn ? 4'b1110 : 4'b1111;
    repeat (4 * nw) @(negedge clk);
  endtask

  task automatic expect_ev(input logic [3:0] c, input logic [15:0] en,
                           input logic [2:0] n, input logic d,
                           input logic [15:0] v);
    exp_t e;
    e.code = c; e.ent = en; e.cnt = n; e.done = d; e.val = v;
    q.push_back(e);
  endtask

  task automatic press(input logic [3:0] c, input logic [15:0] en,
                       input logic [2:0] n, input logic d,
                       input logic [15:0] v);
    expect_ev(c, en, n, d, v);
    align();
    hold(c, 8, 1'b1);
    hold(c, 10, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " key_valid"}, 16'(bus.key_valid), 16'd0);
    chk({tag, " key_code"}, 16'(bus.key_code), 16'd0);
    chk({tag, " entry"}, bus.entry, 16'd0);
    chk({tag, " digit_cnt"}, 16'(bus.digit_cnt), 16'd0);
    chk({tag, " entry_done"}, 16'(bus.entry_done), 16'd0);
    chk({tag, " entry_value"}, bus.entry_value, 16'd0);
  endtask

  initial begin : stim
    bus.SWC = 4'b1111;
    bus.key = 4'd0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    press(4'h5, 16'h0005, 3'd1, 1'b0, 16'h0000);

    align();
    hold(4'h6, 3, 1'b1);
    hold(4'h6, 10, 1'b0);
    chk("short press entry", bus.entry, 16'h0005);
    align();
    hold(4'h6, 7, 1'b1);
    hold(4'h6, 10, 1'b0);
    chk("7-window entry", bus.entry, 16'h0005);

    press(4'hA, 16'h0000, 3'd0, 1'b0, 16'h0000);
    press(4'h1, 16'h0001, 3'd1, 1'b0, 16'h0000);
    press(4'h2, 16'h0012, 3'd2, 1'b0, 16'h0000);
    press(4'h3, 16'h0123, 3'd3, 1'b0, 16'h0000);
    press(4'h4, 16'h1234, 3'd4, 1'b0, 16'h0000);
    press(4'h5, 16'h2345, 3'd4, 1'b0, 16'h0000);
    press(4'hB, 16'h0000, 3'd0, 1'b1, 16'h2345);

    press(4'h7, 16'h0007, 3'd1, 1'b0, 16'h2345);
    press(4'h8, 16'h0078, 3'd2, 1'b0, 16'h2345);
    press(4'hA, 16'h0000, 3'd0, 1'b0, 16'h2345);

    press(4'hB, 16'h0000, 3'd0, 1'b1, 16'h0000);
    press(4'hC, 16'h0000, 3'd0, 1'b0, 16'h0000);

    expect_ev(4'h9, 16'h0009, 3'd1, 1'b0, 16'h0000);
    align();
    hold(4'h9, 8, 1'b1);
    hold(4'h9, 2, 1'b0);
    hold(4'h9, 4, 1'b1);
    hold(4'h9, 10, 1'b0);

    press(4'hA, 16'h0000, 3'd0, 1'b0, 16'h0000);
    expect_ev(4'h3, 16'h0003, 3'd1, 1'b0, 16'h0000);
`ifdef KEY_REPEAT_EN
    expect_ev(4'h3, 16'h0033, 3'd2, 1'b0, 16'h0000);
    expect_ev(4'h3, 16'h0333, 3'd3, 1'b0, 16'h0000);
`endif
    align();
    hold(4'h3, 58, 1'b1);
    hold(4'h3, 10, 1'b0);
`ifdef KEY_REPEAT_EN
    chk("repeat entry", bus.entry, 16'h0333);
`else
    chk("no-repeat entry", bus.entry, 16'h0003);
`endif

`ifdef KEY_REPEAT_EN
    expect_ev(4'h7, 16'h3337, 3'd4, 1'b0, 16'h0000);
`else
    expect_ev(4'h7, 16'h0037, 3'd2, 1'b0, 16'h0000);
`endif
    align();
    hold(4'h7, 20, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("mid-hold reset");
    rst_n = 1'b1;

    expect_ev(4'h7, 16'h0007, 3'd1, 1'b0, 16'h0000);
    align();
    hold(4'h7, 8, 1'b1);
    hold(4'h7, 10, 1'b0);

    align();
    hold(4'h4, 5, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("mid-debounce reset");
    rst_n = 1'b1;
    hold(4'h4, 4, 1'b1);
    hold(4'h4, 10, 1'b0);

    repeat (20) @(negedge clk);
    chk("pending events", 16'(q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/key_entry.md
KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 Parameter DEB_WIN, default 8: number of consecutive scan windows needed to confirm a press or a release (range 1..15).
REQ-002 Parameter REPEAT_DLY, default 40: number of scan windows held before the first auto-repeat.
REQ-003 Parameter REPEAT_PER, default 10: number of scan windows between later auto-repeats.
REQ-004 clk  in  1  the single clock, shared with the scanner; all logic is rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 SWC  in  4  raw keypad column sense lines, active-low; a bit at 0 means a key in the currently driven row is down.
REQ-007 key  in  4  registered key code from the scanner, 0x0..0xF.
REQ-008 key_valid  out  1  one-cycle pulse marking a confirmed key event.
REQ-009 key_code  out  4  code of the last confirmed key; holds its value between events.
REQ-010 entry  out  16  digit buffer, four BCD nibbles, with the newest digit in bits [3:0].
REQ-011 digit_cnt  out  3  number of digits in the buffer, 0..4.
REQ-012 entry_done  out  1  one-cycle pulse marking that ENTER was accepted.
REQ-013 entry_value  out  16  buffer contents captured on ENTER; holds until the next ENTER.

Function
REQ-014 A 2-bit window counter SHALL run freely 0,1,2,3,0,..., so that one window equals one full 4-row scan.
REQ-015 A hit flag SHALL be set in any window cycle where SWC != 4'b1111; at count 3 the block latches raw_pressed = hit (including the current cycle) and clears hit.
REQ-016 The FSM SHALL have four states: IDLE, PRESS_DB, HELD, REL_DB. All transitions are evaluated only at window end (count 3).
REQ-017 IDLE: raw_pressed=1 moves to PRESS_DB with deb_cnt=1; otherwise the FSM stays in IDLE.
REQ-018 PRESS_DB: raw_pressed=1 increments deb_cnt, and reaching DEB_WIN moves to HELD; raw_pressed=0 returns to IDLE and clears deb_cnt.
REQ-019 On entering HELD, key_code SHALL take the current key input, and key_valid SHALL pulse in the same cycle the state register updates.
REQ-020 HELD: raw_pressed=0 moves to REL_DB with deb_cnt=1.
REQ-021 REL_DB: raw_pressed=0 increments deb_cnt, and reaching DEB_WIN moves to IDLE; raw_pressed=1 returns to HELD with no new key_valid.
REQ-022 Each key_valid SHALL apply exactly one action to the buffer, chosen by key_code:
- 0x0..0x9: entry <= {entry[11:0], key_code}; digit_cnt increments and saturates at 4, and with 4 digits the oldest digit is shifted out.
- 0xA (CLEAR): entry <= 0; digit_cnt <= 0.
- 0xB (ENTER): entry_value <= entry; entry_done pulses one cycle later than key_valid; entry and digit_cnt are cleared.
- 0xC..0xF: no buffer change; key_valid still pulses.
REQ-023 ENTER with digit_cnt=0 SHALL still pulse entry_done, with entry_value=0.
REQ-024 Latency from the window end that confirms a press to key_valid SHALL be 1 cycle; from key_valid to the buffer update SHALL be 1 cycle.
REQ-025 No more than one key_valid SHALL occur per window.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear the FSM to IDLE and zero the window counter, hit, deb_cnt, repeat counter, key_valid, key_code, entry, digit_cnt, entry_done and entry_value.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL discard the pending event; after release, a still-held key re-qualifies from IDLE.

Configuration
REQ-028 Macro KEY_REPEAT_EN defined: while in HELD, a window counter SHALL re-pulse key_valid with the same key_code after REPEAT_DLY windows and then every REPEAT_PER windows; each repeat is a full event under REQ-022. The counter clears on leaving HELD.
REQ-029 Macro KEY_REPEAT_EN undefined: no repeat logic is built, and exactly one key_valid occurs per press.

Verification
REQ-030 Hold SWC=4'b1110 in one row for 8 windows with key=0x5, DEB_WIN=8 -> key_valid pulses once, key_code=0x5, entry=0x0005, digit_cnt=1.
REQ-031 A 3-window press followed by release -> no key_valid, and the FSM returns to IDLE.
REQ-032 Press 1,2,3,4,5 in turn -> entry=0x2345, digit_cnt=4; then press 0xB -> entry_done pulses, entry_value=0x2345, entry=0, digit_cnt=0.
REQ-033 Digits 7,8 followed by 0xA -> entry=0, digit_cnt=0, entry_done stays 0.
REQ-034 A 2-window release gap inside a hold -> the FSM goes HELD->REL_DB->HELD with no second key_valid.
REQ-035 With KEY_REPEAT_EN, hold key 0x3 for 8+40+10 windows -> three key_valid pulses, entry=0x0333; pulse rst_n low mid-hold -> all outputs 0, FSM IDLE.
